// File: rtl/clock_pkg.sv
// clock_pkg: shared helpers and channel FSM state for the button conditioner
package clock_pkg;
  typedef enum logic [1:0] {IDLE, PRESS, HOLD, REPEAT} state_t;
  function automatic int ms_to_cyc(input int f_in, input int ms);
    return f_in / 1000 * ms;
  endfunction
endpackage

// File: rtl/button_conditioner_if.sv
// button_conditioner_if: pin-side inputs and conditioned outputs of the button conditioner
interface button_conditioner_if #(parameter int N_BTN = 3);
  logic [N_BTN-1:0] btn_raw;
  logic             consume;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_pulse;
  logic [N_BTN-1:0] btn_evt;
  modport master (output btn_raw, consume, input btn_level, btn_pulse, btn_evt);
  modport slave  (input btn_raw, consume, output btn_level, btn_pulse, btn_evt);
endinterface

// File: rtl/button_conditioner_btn_channel.sv
// btn_channel: sync, debounce, press/repeat FSM and sticky event flag for one button
module btn_channel
  import clock_pkg::*;
#(
  parameter int DB_CYC  = 5,
  parameter int DLY_CYC = 20,
  parameter int PER_CYC = 10,
  parameter bit RPT     = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_pin,
  input  logic i_consume,
  output logic o_level,
  output logic o_pulse,
  output logic o_evt
);
  localparam int MAXC = (DB_CYC > DLY_CYC) ? ((DB_CYC > PER_CYC) ? DB_CYC : PER_CYC)
                                           : ((DLY_CYC > PER_CYC) ? DLY_CYC : PER_CYC);
  localparam int CW = (MAXC > 1) ? $clog2(MAXC) : 1;
  logic r_ff1, r_ff2, r_level, r_pulse, r_evt, w_pulse;
  logic [CW-1:0] r_db_cnt, r_hold_cnt, w_hold_nxt;
  state_t r_state, w_state_nxt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ff1      <= 1'b0;
      r_ff2      <= 1'b0;
      r_level    <= 1'b0;
      r_db_cnt   <= '0;
      r_hold_cnt <= '0;
      r_state    <= IDLE;
      r_pulse    <= 1'b0;
      r_evt      <= 1'b0;
    end else begin
      r_ff1      <= i_pin;
      r_ff2      <= r_ff1;
      r_db_cnt   <= (r_ff2 == r_level || r_db_cnt == CW'(DB_CYC - 1)) ? '0 : r_db_cnt + 1'b1;
      r_level    <= (r_ff2 != r_level && r_db_cnt == CW'(DB_CYC - 1)) ? ~r_level : r_level;
      r_hold_cnt <= w_hold_nxt;
      r_state    <= w_state_nxt;
      r_pulse    <= w_pulse;
      r_evt      <= r_pulse | (r_evt & ~i_consume);
    end
  end
  // Masked buttons freeze the hold counter in HOLD so a long press cannot wrap it
  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold_cnt;
    w_pulse     = 1'b0;
    case (r_state)
      IDLE: if (r_level) begin
        w_state_nxt = PRESS;
        w_hold_nxt  = '0;
        w_pulse     = 1'b1;
      end
      PRESS: begin
        w_state_nxt = HOLD;
        w_hold_nxt  = r_hold_cnt + 1'b1;
      end
      HOLD: if (!r_level) w_state_nxt = IDLE;
      else if (RPT) begin
        w_hold_nxt = (r_hold_cnt == CW'(DLY_CYC - 1)) ? '0 : r_hold_cnt + 1'b1;
        w_pulse    = (r_hold_cnt == CW'(DLY_CYC - 1));
        w_state_nxt = w_pulse ? REPEAT : HOLD;
      end
      REPEAT: if (!r_level) w_state_nxt = IDLE;
      else begin
        w_hold_nxt = (r_hold_cnt == CW'(PER_CYC - 1)) ? '0 : r_hold_cnt + 1'b1;
        w_pulse    = (r_hold_cnt == CW'(PER_CYC - 1));
      end
    endcase
  end
  assign o_level = r_level;
  assign o_pulse = r_pulse;
  assign o_evt   = r_evt;
endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: normalises pin polarity and fans out one btn_channel per button
module button_conditioner
  import clock_pkg::*;
#(
  parameter int               N_BTN         = 3,
  parameter int               F_IN          = 50_000_000,
  parameter int               DEBOUNCE_MS   = 20,
  parameter int               REPEAT_DLY_MS = 500,
  parameter int               REPEAT_PER_MS = 100,
  parameter logic [N_BTN-1:0] REPEAT_MASK   = 3'b011,
  parameter bit               ACTIVE_LOW    = 1'b1
) (
  input logic clk,
  input logic rst_n,
  button_conditioner_if.slave io_bus
);
  localparam int DB_CYC  = ms_to_cyc(F_IN, DEBOUNCE_MS);
  localparam int DLY_CYC = ms_to_cyc(F_IN, REPEAT_DLY_MS);
  localparam int PER_CYC = ms_to_cyc(F_IN, REPEAT_PER_MS);
  logic [N_BTN-1:0] w_pin, w_level, w_pulse, w_evt;
  assign w_pin = ACTIVE_LOW ? ~io_bus.btn_raw : io_bus.btn_raw;
  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_channel #(
      .DB_CYC (DB_CYC),
      .DLY_CYC(DLY_CYC),
      .PER_CYC(PER_CYC),
      .RPT    (REPEAT_MASK[i])
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_pin    (w_pin[i]),
      .i_consume(io_bus.consume),
      .o_level  (w_level[i]),
      .o_pulse  (w_pulse[i]),
      .o_evt    (w_evt[i])
    );
  end
  assign io_bus.btn_level = w_level;
  assign io_bus.btn_pulse = w_pulse;
  assign io_bus.btn_evt   = w_evt;
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed and random stimulus checked against a timing-rule reference model
module tb_button_conditioner;
  localparam int N = 3, DB = 5, DLY = 20, PER = 10;
  localparam logic [2:0] MASK = 3'b011;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] press = 3'b000;
  int total = 0, bad = 0;
  logic [2:0] m_lvl, m_pulse, m_evt;
  int m_run[N], m_age[N];
  bit m_q[N][$];
  button_conditioner_if #(.N_BTN(N)) bus();
  button_conditioner #(
    .N_BTN(N), .F_IN(1000), .DEBOUNCE_MS(5), .REPEAT_DLY_MS(20),
    .REPEAT_PER_MS(10), .REPEAT_MASK(MASK), .ACTIVE_LOW(1'b1)
  ) dut (.clk(clk), .rst_n(rst_n), .io_bus(bus));
  assign bus.btn_raw = ~press;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [2:0] got, input logic [2:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s t=%0t got=%b exp=%b", tag, $time, got, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int got, input int exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_lvl = '0; m_pulse = '0; m_evt = '0;
    for (int i = 0; i < N; i++) begin
      m_run[i] = 0; m_age[i] = 0;
      m_q[i].delete(); m_q[i].push_back(1'b0); m_q[i].push_back(1'b0);
    end
  endtask

  // Pulses fall at press age 1, then age DLY+1 and every PER after that for repeat buttons
  task automatic model_edge(input logic [2:0] p, input bit c);
    for (int i = 0; i < N; i++) begin
      bit s, np;
      m_age[i] = m_lvl[i] ? m_age[i] + 1 : 0;
      np = m_lvl[i] && (m_age[i] == 1 ||
           (MASK[i] && m_age[i] > DLY && (m_age[i] - DLY - 1) % PER == 0));
      m_evt[i] = m_pulse[i] | (m_evt[i] & !c);
      s = m_q[i].pop_front();
      m_q[i].push_back(p[i]);
      if (s != m_lvl[i]) begin
        m_run[i]++;
        if (m_run[i] == DB) begin m_lvl[i] = !m_lvl[i]; m_run[i] = 0; end
      end else m_run[i] = 0;
      m_pulse[i] = np;
    end
  endtask

  task automatic step(input logic [2:0] p, input bit c);
    press = p;
    bus.consume = c;
    @(posedge clk);
    model_edge(p, c);
    #1;
    chk("level", bus.btn_level, m_lvl);
    chk("pulse", bus.btn_pulse, m_pulse);
    chk("evt", bus.btn_evt, m_evt);
  endtask

  task automatic idle(input int n, input bit c);
    for (int k = 0; k < n; k++) step(3'b000, c);
  endtask

  initial begin
    int first, pulses, seen;
    logic [2:0] rp;
    bus.consume = 1'b0;
    model_reset();
    // reset with up held
    press = 3'b001;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_level", bus.btn_level, 3'b000);
    chk("rst_pulse", bus.btn_pulse, 3'b000);
    chk("rst_evt", bus.btn_evt, 3'b000);
    rst_n = 1'b1;
    first = -1; pulses = 0;
    for (int k = 1; k <= 12; k++) begin
      step(3'b001, 1'b0);
      if (bus.btn_level[0] && first < 0) first = k;
      pulses += int'(bus.btn_pulse[0]);
    end
    chk_int("t1_level_cycle", first, 7);
    chk_int("t1_pulses", pulses, 1);
    idle(12, 1'b0);
    idle(1, 1'b1);
    // short glitch on down
    seen = 0;
    for (int k = 0; k < 3; k++) begin
      step(3'b010, 1'b0);
      seen |= int'(bus.btn_level[1] | bus.btn_pulse[1] | bus.btn_evt[1]);
    end
    for (int k = 0; k < 10; k++) begin
      step(3'b000, 1'b0);
      seen |= int'(bus.btn_level[1] | bus.btn_pulse[1] | bus.btn_evt[1]);
    end
    chk_int("t2_glitch_quiet", seen, 0);
    // hold up with auto-repeat
    pulses = 0;
    for (int k = 0; k < 60; k++) begin step(3'b001, 1'b0); pulses += int'(bus.btn_pulse[0]); end
    for (int k = 0; k < 15; k++) begin step(3'b000, 1'b0); pulses += int'(bus.btn_pulse[0]); end
    chk_int("t3_repeat_pulses", pulses, 5);
    idle(1, 1'b1);
    // hold sel_blink, repeat masked
    pulses = 0;
    for (int k = 0; k < 60; k++) begin step(3'b100, 1'b0); pulses += int'(bus.btn_pulse[2]); end
    for (int k = 0; k < 15; k++) begin step(3'b000, 1'b0); pulses += int'(bus.btn_pulse[2]); end
    chk_int("t4_masked_pulses", pulses, 1);
    idle(1, 1'b1);
    // two presses collapse into one sticky flag
    pulses = 0;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 10; k++) begin step(3'b001, 1'b0); pulses += int'(bus.btn_pulse[0]); end
      for (int k = 0; k < 10; k++) step(3'b000, 1'b0);
    end
    chk_int("t5_two_pulses", pulses, 2);
    chk("t5_evt_sticky", bus.btn_evt, 3'b001);
    step(3'b000, 1'b1);
    chk("t5_evt_cleared", bus.btn_evt, 3'b000);
    seen = 0;
    for (int k = 0; k < 15 && !seen; k++) begin
      step(3'b001, 1'b0);
      seen = int'(bus.btn_pulse[0]);
    end
    chk_int("t5_pulse_found", seen, 1);
    step(3'b001, 1'b1);
    chk("t5_evt_new_wins", bus.btn_evt, 3'b001);
    idle(12, 1'b0);
    idle(1, 1'b1);
    // async reset while in REPEAT, button still held
    for (int k = 0; k < 40; k++) step(3'b001, 1'b0);
    chk("t6_pre_level", bus.btn_level, 3'b001);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_level", bus.btn_level, 3'b000);
    chk("t6_async_pulse", bus.btn_pulse, 3'b000);
    chk("t6_async_evt", bus.btn_evt, 3'b000);
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    first = -1; pulses = 0;
    for (int k = 1; k <= 12; k++) begin
      step(3'b001, 1'b0);
      if (bus.btn_level[0] && first < 0) first = k;
      pulses += int'(bus.btn_pulse[0]);
    end
    chk_int("t6_repress_cycle", first, 7);
    chk_int("t6_repress_pulses", pulses, 1);
    idle(12, 1'b1);
    // random pins and consume strobes
    rp = 3'b000;
    for (int k = 0; k < 600; k++) begin
      for (int i = 0; i < N; i++) if ($urandom_range(7) == 0) rp[i] = ~rp[i];
      step(rp, $urandom_range(5) == 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
